// File: rtl/dht_pkg.sv
// Shared types, error codes, frame layout and checksum helper for the DHT11 scheduler.
package dht_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_START,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_SENSOR   = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  localparam int FIELD_W     = 8;
  localparam int HUM_INT_LSB = 32;
  localparam int HUM_DEC_LSB = 24;
  localparam int TMP_INT_LSB = 16;
  localparam int TMP_DEC_LSB = 8;
  localparam int CSUM_LSB    = 0;

  // Sum of the four data bytes, wrapped to 8 bits, must equal the checksum byte.
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[HUM_INT_LSB +: FIELD_W] + frame[HUM_DEC_LSB +: FIELD_W]
        + frame[TMP_INT_LSB +: FIELD_W] + frame[TMP_DEC_LSB +: FIELD_W];
    return sum == frame[CSUM_LSB +: FIELD_W];
  endfunction

endpackage

// File: rtl/dht_scheduler_holdoff_timer.sv
// Saturating down-counter: load a value, count to zero and stay there.
module holdoff_timer #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Val,
  output logic             o_Zero
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: default assignment first so every path drives count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (i_Load) begin
      count_d = i_Load_Val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Zero = (count_q == '0);

endmodule

// File: rtl/dht_scheduler.sv
// DHT11 read sequencer: holdoff between reads, response timeout, checksum and retry.
// Optional read cache enabled by defining DHT_CACHE_EN.
module dht_scheduler
  import dht_pkg::*;
#(
  parameter int INTERVAL_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES  = 5_000_000,
  parameter int MAX_RETRY       = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Req,
  output logic        o_Busy,
  output logic        o_Dth_Start,
  input  logic [39:0] i_Dth_Data,
  input  logic        i_Dth_Done,
  input  logic        i_Dth_Error,
  output logic [39:0] o_Data,
  output logic        o_Valid,
  output logic        o_Cached,
  output logic        o_Error,
  output logic [1:0]  o_Err_Code
);

  localparam int HOLD_W = $clog2(INTERVAL_CYCLES + 1);
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ATT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(INTERVAL_CYCLES - 1);
  localparam logic [TOUT_W-1:0] TOUT_LOAD = TOUT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [39:0]        data_q, data_d;
  logic [39:0]        raw_q, raw_d;
  logic [ATT_W-1:0]   attempt_q, attempt_d;
  logic               fail;
  logic [1:0]         fail_code;
  logic               hold_zero, tout_zero, timers_load;

  // Holdoff runs independently of the FSM; reset value covers the sensor power-up delay.
  assign timers_load = (state_q == S_START);

  holdoff_timer #(.WIDTH(HOLD_W), .RESET_VAL(HOLD_LOAD)) u_holdoff (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Load    (timers_load),
    .i_Load_Val(HOLD_LOAD),
    .o_Zero    (hold_zero)
  );

  holdoff_timer #(.WIDTH(TOUT_W), .RESET_VAL('0)) u_timeout (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Load    (timers_load),
    .i_Load_Val(TOUT_LOAD),
    .o_Zero    (tout_zero)
  );

`ifdef DHT_CACHE_EN
  logic cached_q, cached_d;
  logic cache_valid_q, cache_valid_d;
`endif

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    data_d     = data_q;
    raw_d      = raw_q;
    attempt_d  = attempt_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
`ifdef DHT_CACHE_EN
    cached_d      = cached_q;
    cache_valid_d = cache_valid_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_Req) begin
          state_d   = S_HOLD;
          busy_d    = 1'b1;
          attempt_d = '0;
`ifdef DHT_CACHE_EN
          if (!hold_zero && cache_valid_q) begin
            state_d  = S_DONE;
            busy_d   = 1'b0;
            valid_d  = 1'b1;
            cached_d = 1'b1;
          end
`endif
        end
      end
      S_HOLD: begin
        if (hold_zero) begin
          state_d = S_START;
          start_d = 1'b1;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_Dth_Error) begin
          fail      = 1'b1;
          fail_code = ERR_SENSOR;
        end else if (i_Dth_Done) begin
          raw_d   = i_Dth_Data;
          state_d = S_CHECK;
        end else if (tout_zero) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      S_CHECK: begin
        if (checksum_ok(raw_q)) begin
          data_d     = raw_q;
          err_code_d = ERR_NONE;
          state_d    = S_DONE;
          busy_d     = 1'b0;
          valid_d    = 1'b1;
`ifdef DHT_CACHE_EN
          cached_d      = 1'b0;
          cache_valid_d = 1'b1;
`endif
        end else begin
          fail      = 1'b1;
          fail_code = ERR_CHECKSUM;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      err_code_d = fail_code;
      if (attempt_q < ATT_W'(MAX_RETRY)) begin
        attempt_d = attempt_q + 1'b1;
        state_d   = S_HOLD;
      end else begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      data_q     <= '0;
      attempt_q  <= '0;
`ifdef DHT_CACHE_EN
      cached_q      <= 1'b0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      data_q     <= data_d;
      attempt_q  <= attempt_d;
`ifdef DHT_CACHE_EN
      cached_q      <= cached_d;
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  // NOTE: the raw capture register is only read after a fresh capture, so it needs no reset.
  always_ff @(posedge i_Clock) begin
    raw_q <= raw_d;
  end

  assign o_Busy      = busy_q;
  assign o_Dth_Start = start_q;
  assign o_Valid     = valid_q;
  assign o_Error     = error_q;
  assign o_Err_Code  = err_code_q;
  assign o_Data      = data_q;
`ifdef DHT_CACHE_EN
  assign o_Cached    = cached_q;
`else
  assign o_Cached    = 1'b0;
`endif

endmodule

// File: tb/tb_dht_scheduler.sv
// Self-checking bench for dht_scheduler: per-cycle compare against a timeline model
// built from the read/holdoff/timeout/retry rules, plus hand-computed cycle literals.
module tb_dht_scheduler;

  localparam int INTERVAL = 100;
  localparam int TIMEOUT  = 50;
  localparam int RETRIES  = 2;
  localparam int NC       = 1250;
  localparam int END_CYC  = 1180;

  typedef enum {K_FRAME, K_ERR, K_BOTH, K_SILENT} kind_e;
  typedef struct {
    kind_e       kind;
    int          delay;
    logic [39:0] frame;
  } resp_t;
  typedef struct {
    int          at;
    kind_e       kind;
    logic [39:0] frame;
  } pulse_t;

  logic        clk = 1'b0;
  logic        i_Reset, i_Req, i_Dth_Done, i_Dth_Error;
  logic [39:0] i_Dth_Data;
  logic        o_Busy, o_Dth_Start, o_Valid, o_Cached, o_Error;
  logic [39:0] o_Data;
  logic [1:0]  o_Err_Code;

  dht_scheduler #(
    .INTERVAL_CYCLES(INTERVAL),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRY      (RETRIES)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (i_Reset),
    .i_Req      (i_Req),
    .o_Busy     (o_Busy),
    .o_Dth_Start(o_Dth_Start),
    .i_Dth_Data (i_Dth_Data),
    .i_Dth_Done (i_Dth_Done),
    .i_Dth_Error(i_Dth_Error),
    .o_Data     (o_Data),
    .o_Valid    (o_Valid),
    .o_Cached   (o_Cached),
    .o_Error    (o_Error),
    .o_Err_Code (o_Err_Code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, written only by the stimulus process.
  bit          exp_start [NC];
  bit          exp_valid [NC];
  bit          exp_error [NC];
  bit          exp_busy  [NC];
  bit          exp_cached[NC];
  logic [39:0] exp_data  [NC];
  logic [1:0]  exp_code  [NC];
  int          z_cyc;        // first cycle in which the holdoff has expired
  bit          cache_ok;
  logic [39:0] m_data;
  logic [1:0]  m_code;
  resp_t       cur[$];
  resp_t       drv_q[$];
  pulse_t      stray_q[$];
  bit          tb_done = 1'b0;

  function automatic resp_t mk(input kind_e k, input int d, input logic [39:0] f);
    resp_t r;
    r.kind = k; r.delay = d; r.frame = f;
    return r;
  endfunction

  function automatic bit frame_good(input logic [39:0] f);
    int sum = 0;
    for (int b = 1; b <= 4; b++) sum += int'((f >> (8 * b)) & 40'hFF);
    return (sum % 256) == int'(f[7:0]);
  endfunction

  task automatic set_busy(input int lo, input int hi);
    for (int i = lo; i <= hi && i < NC; i++) exp_busy[i] = 1'b1;
  endtask

  // Predict the outcome of a request raised during cycle c, given driver responses in cur.
  task automatic plan(input int c);
    int h, s, nx;
`ifdef DHT_CACHE_EN
    if (cache_ok && c < z_cyc) begin
      exp_valid[c+1]  = 1'b1;
      exp_cached[c+1] = 1'b1;
      exp_data[c+1]   = m_data;
      exp_code[c+1]   = m_code;
      return;
    end
`endif
    h = c + 1;
    for (int a = 0; a < cur.size(); a++) begin
      s = ((h > z_cyc) ? h : z_cyc) + 1;
      exp_start[s] = 1'b1;
      z_cyc = s + INTERVAL;
      drv_q.push_back(cur[a]);
      case (cur[a].kind)
        K_FRAME: begin
          nx = s + cur[a].delay + 2;
          if (frame_good(cur[a].frame)) begin
            set_busy(c + 1, nx - 1);
            m_data = cur[a].frame; m_code = 2'b00; cache_ok = 1'b1;
            exp_valid[nx] = 1'b1; exp_cached[nx] = 1'b0;
            exp_data[nx] = m_data; exp_code[nx] = m_code;
            return;
          end
          m_code = 2'b11;
        end
        K_ERR, K_BOTH: begin nx = s + cur[a].delay + 1; m_code = 2'b10; end
        default:       begin nx = s + TIMEOUT + 1;      m_code = 2'b01; end
      endcase
      if (a == RETRIES) begin
        set_busy(c + 1, nx - 1);
        exp_error[nx] = 1'b1;
        exp_code[nx]  = m_code;
        return;
      end
      h = nx;
    end
    set_busy(c + 1, NC - 1);  // outcome not reached; a reset is expected to cut it short
  endtask

  task automatic reset_model(input int r);
    for (int i = r; i < NC; i++) begin
      exp_start[i] = 0; exp_valid[i] = 0; exp_error[i] = 0; exp_busy[i] = 0; exp_cached[i] = 0;
    end
    z_cyc = r + INTERVAL - 1;
    m_data = '0; m_code = 2'b00; cache_ok = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input int c);
    wait_until(c);
    plan(c);
    i_Req = 1'b1;
    @(posedge clk); #1;
    i_Req = 1'b0;
  endtask

  // Stimulus and model
  initial begin
    i_Reset = 1'b1;
    i_Req   = 1'b0;
    reset_model(3);
    stray_q.push_back('{780,  K_FRAME, 40'h370018004F});
    stray_q.push_back('{1055, K_FRAME, 40'h370018004F});
    wait_until(3);
    i_Reset = 1'b0;

    cur.delete(); cur.push_back(mk(K_FRAME, 5, 40'h370018004F));
    request(10);

    cur.delete();
    cur.push_back(mk(K_FRAME, 4, 40'h3700180050));
    cur.push_back(mk(K_FRAME, 4, 40'h370018004F));
    request(210);

    cur.delete();
    for (int i = 0; i < 3; i++) cur.push_back(mk(K_SILENT, 0, '0));
    request(420);

    cur.delete();
    cur.push_back(mk(K_BOTH, 3, 40'h370018004F));
    cur.push_back(mk(K_FRAME, 6, 40'h2A05190A52));
    request(730);
    wait_until(790);
    i_Req = 1'b1;  // arrives while busy: must be dropped
    @(posedge clk); #1;
    i_Req = 1'b0;

    cur.delete(); cur.push_back(mk(K_FRAME, 2, 40'h370018004F));
    request(861);

    cur.delete(); cur.push_back(mk(K_SILENT, 0, '0));
    request(1040);
    wait_until(1050);
    reset_model(1051);
    i_Reset = 1'b1;
    wait_until(1051);
    i_Reset = 1'b0;

    cur.delete(); cur.push_back(mk(K_FRAME, 3, 40'h370018004F));
    request(1070);
    wait_until(END_CYC);
    tb_done = 1'b1;
  end

  // DHT11 driver stand-in: answers each start with the next queued response.
  initial begin : driver
    int     idx = 0;
    pulse_t pend[$];
    i_Dth_Done  = 1'b0;
    i_Dth_Error = 1'b0;
    i_Dth_Data  = '0;
    forever begin
      @(posedge clk); #1;
      i_Dth_Done  = 1'b0;
      i_Dth_Error = 1'b0;
      if (o_Dth_Start && idx < drv_q.size()) begin
        if (drv_q[idx].kind != K_SILENT)
          pend.push_back('{cyc + drv_q[idx].delay, drv_q[idx].kind, drv_q[idx].frame});
        idx++;
      end
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].at == cyc) begin
          i_Dth_Done  = (pend[i].kind == K_FRAME) || (pend[i].kind == K_BOTH);
          i_Dth_Error = (pend[i].kind == K_ERR)   || (pend[i].kind == K_BOTH);
          i_Dth_Data  = pend[i].frame;
        end
      end
      for (int i = 0; i < stray_q.size(); i++) begin
        if (stray_q[i].at == cyc) begin
          i_Dth_Done = 1'b1;
          i_Dth_Data = stray_q[i].frame;
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Single compare process: per-cycle model compare, then cycle literals and summary.
  initial begin : compare
    int starts[$];
    int valids[$];
    int errors[$];
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < NC) begin
        check("start", o_Dth_Start, exp_start[cyc]);
        check("valid", o_Valid,     exp_valid[cyc]);
        check("error", o_Error,     exp_error[cyc]);
        check("busy",  o_Busy,      exp_busy[cyc]);
        if (exp_valid[cyc]) begin
          check("valid_data",   o_Data,     exp_data[cyc]);
          check("valid_cached", o_Cached,   exp_cached[cyc]);
          check("valid_code",   o_Err_Code, exp_code[cyc]);
        end
        if (exp_error[cyc]) check("error_code", o_Err_Code, exp_code[cyc]);
      end
      if (o_Dth_Start) starts.push_back(cyc);
      if (o_Valid)     valids.push_back(cyc);
      if (o_Error)     errors.push_back(cyc);
      if (cyc == 3) begin
        check("reset_data",   o_Data,     40'h0);
        check("reset_code",   o_Err_Code, 2'b00);
        check("reset_cached", o_Cached,   1'b0);
        check("reset_busy",   o_Busy,     1'b0);
      end
      if (cyc == 785) check("code_after_both", o_Err_Code, 2'b10);
      if (cyc == 1052) begin
        check("midreset_data", o_Data,     40'h0);
        check("midreset_code", o_Err_Code, 2'b00);
      end
      if (tb_done || cyc >= NC) break;
    end
    check("run_complete", tb_done, 1'b1);
`ifdef DHT_CACHE_EN
    check("start_count", starts.size(), 10);
    check("cached_valid_cycle", (valids.size() > 3) ? valids[3] : -1, 862);
`else
    check("start_count", starts.size(), 11);
    check("holdoff_start_cycle", (starts.size() > 8) ? starts[8] : -1, 934);
`endif
    check("first_start_cycle", (starts.size() > 0) ? starts[0] : -1, 103);
    check("first_valid_cycle", (valids.size() > 0) ? valids[0] : -1, 110);
    check("retry_start_cycle", (starts.size() > 1) ? starts[1] : -1, 212);
    check("error_cycle",       (errors.size() > 0) ? errors[0] : -1, 675);
    check("valid_count", valids.size(), 5);
    check("error_count", errors.size(), 1);
    for (int i = 1; i < starts.size(); i++)
      check("start_spacing", (starts[i] - starts[i-1]) >= INTERVAL, 1'b1);
    check("final_data", o_Data, 40'h370018004F);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
